motor_relay_sequencer: RTL and testbench
========================================

Name: motor_relay_sequencer

Overview:
- Registered stage downstream of the combinational motor decoder.
- Takes its four relay commands: right forward/reverse and left forward/reverse, already gated by the run enable.
- Drives the physical relay outputs. Per motor it enforces break-before-make dead-time, a minimum on-time against relay chatter, and rejection of illegal forward+reverse commands.
- Two identical per-motor channels (right, left) share one clock, one reset and one fault flag.

Parameters:
- DEAD_CYC, 8, cycles both relays of a motor stay low between leaving a drive state and entering the next one; legal range 1..2^CNT_W-1.
- MIN_ON, 16, minimum cycles a drive state is held before a direction reversal is accepted; 0 means reversal is accepted at once; legal range 0..2^CNT_W-1.
- CNT_W, 8, width of each per-channel counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- Rd  input  1  right motor forward command.
- R_Rd  input  1  right motor reverse command.
- Re  input  1  left motor forward command.
- R_Re  input  1  left motor reverse command.
- clr_fault  input  1  synchronous clear of the fault flag.
- rele_rd  output  1  right forward relay drive.
- rele_r_rd  output  1  right reverse relay drive.
- rele_re  output  1  left forward relay drive.
- rele_r_re  output  1  left reverse relay drive.
- fault  output  1  sticky: an illegal command pair was seen on either motor.
- busy  output  1  high while either channel is in DEAD.

Behaviour:
- Reset (rst_n low, asynchronous):
  - Both channels go to IDLE and both counters clear.
  - All relay outputs, fault and busy are 0.
  - All outputs are registered, so no combinational path runs from inputs to outputs.
- Per-channel command decode: fwd-only gives CMD_FWD, rev-only gives CMD_REV, neither gives CMD_OFF, both gives CMD_ILL. CMD_ILL is treated as CMD_OFF for state transitions.
- States per channel: IDLE, FWD, REV, DEAD.
  - Relay outputs are a state decode: FWD drives the fwd relay only, REV drives the rev relay only, IDLE and DEAD drive both low.
  - Both relays of one motor are never high in the same cycle, under any input sequence.
- IDLE:
  - CMD_FWD or CMD_REV moves to FWD or REV at the next edge, so the relay rises 1 cycle after the command is sampled.
  - On entry to FWD or REV the on-counter clears.
- FWD (REV is symmetric):
  - On-counter increments each cycle and saturates at MIN_ON.
  - CMD_FWD: stay.
  - CMD_OFF or CMD_ILL: go to DEAD immediately. A stop is never delayed by MIN_ON.
  - CMD_REV with on-counter >= MIN_ON: go to DEAD.
  - CMD_REV with on-counter < MIN_ON: hold FWD with the relay still driven; the request is re-evaluated each cycle.
- DEAD:
  - Dead-counter loads 0 on entry and increments each cycle.
  - Relays stay low for exactly DEAD_CYC cycles.
  - At the edge ending the DEAD_CYC-th cycle, the next state is decoded from the current command: FWD, REV, or IDLE for CMD_OFF/ILL.
  - Commands during DEAD are not latched; only the command at DEAD exit matters.
  - A same-direction re-request also pays the full dead-time.
- fault:
  - Set at the edge after CMD_ILL is sampled on either channel.
  - Stays set until clr_fault is high at an edge.
  - If set and clear happen in the same cycle, set wins.
- busy: OR of both channels being in DEAD, registered along with the state.
- Channels are fully independent. Simultaneous transitions on both motors are legal and do not interact.
- Reset mid-DEAD or mid-drive drops the relays low at once, asynchronously. After release, the channel starts in IDLE with no dead-time owed.

Test Plan:
- Bench parameters DEAD_CYC=4, MIN_ON=6.
- Reset then Rd=1 sampled at edge 0 -> rele_rd=1 from edge 1; rele_r_rd, rele_re and rele_r_re stay 0; fault=0; busy=0.
- Rd held 10 cycles, then Rd=0,R_Rd=1 -> rele_rd falls at the next edge; both right relays are 0 for exactly 4 cycles with busy=1; then rele_r_rd=1.
- Rd asserted, reversed to R_Rd after 2 cycles -> rele_rd stays 1 until the on-count reaches 6, then 4 dead cycles, then rele_r_rd=1; the two right relays are never both 1.
- Re=1,R_Re=1 for 1 cycle -> left relays both 0, fault=1 and sticky across 20 cycles. Pulse clr_fault -> fault=0 at the next edge. Repeat with CMD_ILL and clr_fault together -> fault stays 1.
- Right and left driven forward, both commands dropped in the same cycle -> both channels enter DEAD together, busy=1 for 4 cycles, then both IDLE with all relays 0.
- rst_n pulsed low mid-FWD and mid-DEAD -> all relay outputs 0 immediately without waiting for a clock. After release, Re=1 -> rele_re=1 one cycle later with no dead-time.

Source files
------------

// File: rtl/motor_relay_sequencer.sv
// motor_relay_sequencer
//   Registered relay driver behind the motor decoder. Each motor channel
//   enforces break-before-make dead-time, a minimum on-time before a direction
//   reversal is accepted, and treats forward+reverse together as a stop while
//   flagging it as a sticky fault.
//
// Ports
//   clk, rst_n            clock (rising edge), async active-low reset
//   Rd, R_Rd              right motor forward / reverse command
//   Re, R_Re              left motor forward / reverse command
//   clr_fault             synchronous clear of the fault flag
//   rele_rd, rele_r_rd    right forward / reverse relay drive
//   rele_re, rele_r_re    left forward / reverse relay drive
//   fault                 sticky illegal-command flag (either motor)
//   busy                  either channel currently in dead-time

// One motor channel: fwd/rev relay pair with dead-time and min on-time.
module motor_relay_channel #(
    parameter int DEAD_CYC = 8,
    parameter int MIN_ON   = 16,
    parameter int CNT_W    = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic cmd_fwd,
    input  logic cmd_rev,
    output logic rele_fwd,
    output logic rele_rev,
    output logic in_dead,
    output logic illegal
);
    typedef enum logic [1:0] {S_IDLE, S_FWD, S_REV, S_DEAD} state_t;

    localparam logic [CNT_W-1:0] MIN_ON_C  = CNT_W'(MIN_ON);
    localparam logic [CNT_W-1:0] DEAD_LAST = CNT_W'(DEAD_CYC - 1);

    state_t           state, state_nx;
    // One counter per channel: on-time while driving, dead-time while in DEAD.
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic             want_fwd, want_rev;

    // Illegal pair decodes to neither want, i.e. behaves as OFF.
    assign want_fwd = cmd_fwd & ~cmd_rev;
    assign want_rev = cmd_rev & ~cmd_fwd;
    assign illegal  = cmd_fwd & cmd_rev;

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        case (state)
            S_IDLE: begin
                if (want_fwd) begin
                    state_nx = S_FWD;
                    cnt_nx   = '0;
                end else if (want_rev) begin
                    state_nx = S_REV;
                    cnt_nx   = '0;
                end
            end
            S_FWD, S_REV: begin
                if ((state == S_FWD && want_fwd) || (state == S_REV && want_rev)) begin
                    if (cnt != MIN_ON_C) cnt_nx = cnt + 1'b1;
                end else if ((state == S_FWD && want_rev) || (state == S_REV && want_fwd)) begin
                    // Reversal waits out the minimum on-time with the relay still held.
                    if (cnt >= MIN_ON_C) begin
                        state_nx = S_DEAD;
                        cnt_nx   = '0;
                    end else begin
                        cnt_nx = cnt + 1'b1;
                    end
                end else begin
                    // Stop (or illegal pair) is never delayed.
                    state_nx = S_DEAD;
                    cnt_nx   = '0;
                end
            end
            S_DEAD: begin
                if (cnt == DEAD_LAST) begin
                    // Only the command present at exit matters.
                    cnt_nx = '0;
                    if (want_fwd)      state_nx = S_FWD;
                    else if (want_rev) state_nx = S_REV;
                    else               state_nx = S_IDLE;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            default: begin
                state_nx = S_IDLE;
                cnt_nx   = '0;
            end
        endcase
    end

    // Outputs are registered from the next state so they never follow inputs
    // combinationally and always match the state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            cnt      <= '0;
            rele_fwd <= 1'b0;
            rele_rev <= 1'b0;
            in_dead  <= 1'b0;
        end else begin
            state    <= state_nx;
            cnt      <= cnt_nx;
            rele_fwd <= (state_nx == S_FWD);
            rele_rev <= (state_nx == S_REV);
            in_dead  <= (state_nx == S_DEAD);
        end
    end
endmodule

module motor_relay_sequencer #(
    parameter int DEAD_CYC = 8,
    parameter int MIN_ON   = 16,
    parameter int CNT_W    = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic Rd,
    input  logic R_Rd,
    input  logic Re,
    input  logic R_Re,
    input  logic clr_fault,
    output logic rele_rd,
    output logic rele_r_rd,
    output logic rele_re,
    output logic rele_r_re,
    output logic fault,
    output logic busy
);
    localparam int NUM_LANES = 2;  // lane 0 = right motor, lane 1 = left motor

    logic [NUM_LANES-1:0] cmd_f, cmd_r, rl_f, rl_r, dead, ill;

    assign cmd_f = {Re, Rd};
    assign cmd_r = {R_Re, R_Rd};

    generate
        for (genvar g = 0; g < NUM_LANES; g++) begin : g_ch
            motor_relay_channel #(
                .DEAD_CYC(DEAD_CYC),
                .MIN_ON  (MIN_ON),
                .CNT_W   (CNT_W)
            ) u_ch (
                .clk     (clk),
                .rst_n   (rst_n),
                .cmd_fwd (cmd_f[g]),
                .cmd_rev (cmd_r[g]),
                .rele_fwd(rl_f[g]),
                .rele_rev(rl_r[g]),
                .in_dead (dead[g]),
                .illegal (ill[g])
            );
        end
    endgenerate

    assign rele_rd   = rl_f[0];
    assign rele_r_rd = rl_r[0];
    assign rele_re   = rl_f[1];
    assign rele_r_re = rl_r[1];
    // OR of the registered dead flags: still purely flop-driven.
    assign busy      = |dead;

    // Set has priority over clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) fault <= 1'b0;
        else        fault <= (|ill) | (fault & ~clr_fault);
    end
endmodule

// File: tb/tb_motor_relay_sequencer.sv
module tb_motor_relay_sequencer;
    localparam int DEAD_CYC = 4;
    localparam int MIN_ON   = 6;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic Rd = 0, R_Rd = 0, Re = 0, R_Re = 0, clr_fault = 0;
    logic rele_rd, rele_r_rd, rele_re, rele_r_re, fault, busy;
    int   errors = 0;
    int   checks = 0;

    // {rele_rd, rele_r_rd, rele_re, rele_r_re, fault, busy}
    wire [5:0] obs = {rele_rd, rele_r_rd, rele_re, rele_r_re, fault, busy};

    motor_relay_sequencer #(.DEAD_CYC(DEAD_CYC), .MIN_ON(MIN_ON), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .Rd(Rd), .R_Rd(R_Rd), .Re(Re), .R_Re(R_Re), .clr_fault(clr_fault),
        .rele_rd(rele_rd), .rele_r_rd(rele_r_rd), .rele_re(rele_re), .rele_r_re(rele_r_re),
        .fault(fault), .busy(busy)
    );

    always #5 clk = ~clk;

    // Break-before-make watchdog: never both relays of one motor high.
    always @(negedge clk) begin
        if (rst_n) begin
            checks++;
            if ((rele_rd && rele_r_rd) || (rele_re && rele_r_re)) begin
                errors++;
                $display("FAIL overlap t=%0t obs=%b required no fwd+rev pair", $time, obs);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drop all commands and let any dead-time finish.
    task automatic settle();
        Rd = 0; R_Rd = 0; Re = 0; R_Re = 0; clr_fault = 0;
        repeat (DEAD_CYC + 2) step();
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if (obs !== 6'b000000) begin
            errors++; $display("FAIL reset obs=%b required 000000", obs);
        end
        step(); step();
        rst_n = 1'b1;
        step();
        checks++;
        if (obs !== 6'b000000) begin
            errors++; $display("FAIL post_reset obs=%b required 000000", obs);
        end
    endtask

    task automatic test_fwd_then_rev();
        Rd = 1;
        step();
        checks++;
        if (obs !== 6'b100000) begin
            errors++; $display("FAIL fwd_start obs=%b required 100000", obs);
        end
        repeat (9) begin
            step();
            checks++;
            if (obs !== 6'b100000) begin
                errors++; $display("FAIL fwd_hold obs=%b required 100000", obs);
            end
        end
        Rd = 0; R_Rd = 1;
        for (int i = 0; i < DEAD_CYC; i++) begin
            step();
            checks++;
            if (obs !== 6'b000001) begin
                errors++; $display("FAIL rev_dead%0d obs=%b required 000001", i, obs);
            end
        end
        step();
        checks++;
        if (obs !== 6'b010000) begin
            errors++; $display("FAIL rev_on obs=%b required 010000", obs);
        end
        settle();
    endtask

    task automatic test_min_on();
        Rd = 1;
        step();   // enter FWD, on-count 0
        step();   // on-count 1
        Rd = 0; R_Rd = 1;
        // Count climbs 1..6 while held; reversal accepted on the edge seeing 6.
        for (int i = 0; i < MIN_ON - 1; i++) begin
            step();
            checks++;
            if (obs !== 6'b100000) begin
                errors++; $display("FAIL minon_hold%0d obs=%b required 100000", i, obs);
            end
        end
        for (int i = 0; i < DEAD_CYC; i++) begin
            step();
            checks++;
            if (obs !== 6'b000001) begin
                errors++; $display("FAIL minon_dead%0d obs=%b required 000001", i, obs);
            end
        end
        step();
        checks++;
        if (obs !== 6'b010000) begin
            errors++; $display("FAIL minon_rev obs=%b required 010000", obs);
        end
        settle();
    endtask

    task automatic test_fault();
        Re = 1; R_Re = 1;
        step();
        checks++;
        if (obs !== 6'b000010) begin
            errors++; $display("FAIL ill_set obs=%b required 000010", obs);
        end
        Re = 0; R_Re = 0;
        repeat (20) step();
        checks++;
        if (obs !== 6'b000010) begin
            errors++; $display("FAIL ill_sticky obs=%b required 000010", obs);
        end
        clr_fault = 1;
        step();
        clr_fault = 0;
        checks++;
        if (fault !== 1'b0) begin
            errors++; $display("FAIL ill_clear fault=%b required 0", fault);
        end
        Re = 1; R_Re = 1; clr_fault = 1;
        step();
        checks++;
        if (fault !== 1'b1) begin
            errors++; $display("FAIL set_beats_clear fault=%b required 1", fault);
        end
        Re = 0; R_Re = 0;
        step();
        clr_fault = 0;
        checks++;
        if (fault !== 1'b0) begin
            errors++; $display("FAIL ill_clear2 fault=%b required 0", fault);
        end
        settle();
    endtask

    task automatic test_both_stop();
        Rd = 1; Re = 1;
        repeat (3) step();
        checks++;
        if (obs !== 6'b101000) begin
            errors++; $display("FAIL both_fwd obs=%b required 101000", obs);
        end
        Rd = 0; Re = 0;
        for (int i = 0; i < DEAD_CYC; i++) begin
            step();
            checks++;
            if (obs !== 6'b000001) begin
                errors++; $display("FAIL both_dead%0d obs=%b required 000001", i, obs);
            end
        end
        step();
        checks++;
        if (obs !== 6'b000000) begin
            errors++; $display("FAIL both_idle obs=%b required 000000", obs);
        end
        settle();
    endtask

    task automatic test_reset_mid();
        Rd = 1;
        step();
        checks++;
        if (rele_rd !== 1'b1) begin
            errors++; $display("FAIL mid_fwd_on rele_rd=%b required 1", rele_rd);
        end
        #2 rst_n = 0;
        #1;
        checks++;
        if (obs !== 6'b000000) begin
            errors++; $display("FAIL async_rst_fwd obs=%b required 000000", obs);
        end
        Rd = 0;
        #2 rst_n = 1;
        Rd = 1;
        step();
        Rd = 0;
        step();
        checks++;
        if (obs !== 6'b000001) begin
            errors++; $display("FAIL mid_dead obs=%b required 000001", obs);
        end
        #2 rst_n = 0;
        #1;
        checks++;
        if (obs !== 6'b000000) begin
            errors++; $display("FAIL async_rst_dead obs=%b required 000000", obs);
        end
        #2 rst_n = 1;
        Re = 1;
        step();
        checks++;
        if (obs !== 6'b001000) begin
            errors++; $display("FAIL post_rst_left obs=%b required 001000", obs);
        end
        settle();
    endtask

    initial begin
        test_reset();
        test_fwd_then_rev();
        test_min_on();
        test_fault();
        test_both_stop();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
